// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared widths, store-buffer entry type and address helper for the data-memory responder
package riscv_mem_pkg;

  localparam int ADDR_BITWIDTH = 10;
  localparam int WORD_BITWIDTH = 32;
  localparam int SB_DEPTH      = 4;

  typedef struct packed {
    logic [ADDR_BITWIDTH-1:0] index;
    logic [WORD_BITWIDTH-1:0] data;
  } sb_entry_t;

  // Word accesses only: byte-offset bits and everything above the array are dropped.
  function automatic logic [ADDR_BITWIDTH-1:0] word_index(input logic [31:0] byte_addr);
    return byte_addr[ADDR_BITWIDTH+1:2];
  endfunction

endpackage

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-store FIFO with youngest-match lookup; SB_COALESCE_EN merges stores into a matching entry
module store_buffer
  import riscv_mem_pkg::*;
#(
  parameter int SB_DEPTH = riscv_mem_pkg::SB_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enq_i,
  input  sb_entry_t                   enq_entry_i,
  input  logic                        drain_en_i,
  input  logic [ADDR_BITWIDTH-1:0]    lookup_index_i,
  output logic                        hit_o,
  output logic [WORD_BITWIDTH-1:0]    hit_data_o,
  output logic                        drain_o,
  output sb_entry_t                   head_entry_o,
  output logic [$clog2(SB_DEPTH):0]   count_o,
  output logic                        empty_o
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t        entries [SB_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             deq;
  logic             match;
  logic [PTR_W-1:0] match_ptr;
  logic             coalesce;
  logic             enq_do;

  assign deq = drain_en_i && (count != '0);

  // Walk oldest to youngest so the last valid match wins.
  always_comb begin
    match     = 1'b0;
    match_ptr = head;
    for (int k = 0; k < SB_DEPTH; k++) begin
      if ((CNT_W'(k) < count) && (entries[head + PTR_W'(k)].index == lookup_index_i)) begin
        match     = 1'b1;
        match_ptr = head + PTR_W'(k);
      end
    end
  end

`ifdef SB_COALESCE_EN
  // A head entry leaving this edge cannot absorb the store, so it enqueues instead.
  assign coalesce = enq_i && match && !(deq && (match_ptr == head));
`else
  assign coalesce = 1'b0;
`endif

  assign enq_do = enq_i && !coalesce;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_do) tail <= tail + 1'b1;
      if (deq)    head <= head + 1'b1;
      count <= count + CNT_W'(enq_do) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (enq_do)   entries[tail]          <= enq_entry_i;
    if (coalesce) entries[match_ptr].data <= enq_entry_i.data;
  end

  assign hit_o        = match;
  assign hit_data_o   = entries[match_ptr].data;
  assign drain_o      = deq;
  assign head_entry_o = entries[head];
  assign count_o      = count;
  assign empty_o      = (count == '0);

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - zero-wait data-memory responder with posted store buffer (optional SB_COALESCE_EN)
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_BITWIDTH = riscv_mem_pkg::ADDR_BITWIDTH,
  parameter int WORD_BITWIDTH = riscv_mem_pkg::WORD_BITWIDTH,
  parameter int SB_DEPTH      = riscv_mem_pkg::SB_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_ce_i,
  input  logic                       data_we_i,
  input  logic [31:0]                data_addr_i,
  input  logic [WORD_BITWIDTH-1:0]   data_i,
  output logic [WORD_BITWIDTH-1:0]   data_o,
  output logic [$clog2(SB_DEPTH):0]  sb_count_o,
  output logic                       sb_empty_o
);

  logic [WORD_BITWIDTH-1:0] mem [2**ADDR_BITWIDTH];

  logic [ADDR_BITWIDTH-1:0] index;
  sb_entry_t                store_entry;
  sb_entry_t                head_entry;
  logic                     hit;
  logic [WORD_BITWIDTH-1:0] hit_data;
  logic                     drain;
  logic                     unused_addr_bits;

  assign index            = word_index(data_addr_i);
  assign store_entry      = '{index: index, data: data_i};
  assign unused_addr_bits = ^{data_addr_i[31:ADDR_BITWIDTH+2], data_addr_i[1:0]};

  // The single array port belongs to loads; the buffer only drains on load-free cycles.
  store_buffer #(
    .SB_DEPTH (SB_DEPTH)
  ) u_store_buffer (
    .clk            (clk),
    .rst            (rst),
    .enq_i          (data_we_i),
    .enq_entry_i    (store_entry),
    .drain_en_i     (!data_ce_i),
    .lookup_index_i (index),
    .hit_o          (hit),
    .hit_data_o     (hit_data),
    .drain_o        (drain),
    .head_entry_o   (head_entry),
    .count_o        (sb_count_o),
    .empty_o        (sb_empty_o)
  );

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (drain) mem[head_entry.index] <= head_entry.data;
  end

  always_comb begin
    data_o = '0;
    if (data_ce_i) data_o = hit ? hit_data : mem[index];
  end

  a_no_load_and_store : assert property (@(posedge clk) disable iff (!rst) !(data_ce_i && data_we_i));

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        data_ce_i;
  logic        data_we_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [2:0]  sb_count_o;
  logic        sb_empty_o;

  int checks = 0;
  int errors = 0;

  data_mem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .data_ce_i   (data_ce_i),
    .data_we_i   (data_we_i),
    .data_addr_i (data_addr_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .sb_count_o  (sb_count_o),
    .sb_empty_o  (sb_empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] d);
    data_we_i   = 1'b1;
    data_addr_i = addr;
    data_i      = d;
    step();
    data_we_i   = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    data_ce_i   = 1'b1;
    data_addr_i = addr;
    #2;
    check(tag, data_o, exp);
    step();
    data_ce_i   = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    data_ce_i   = 1'b0;
    data_we_i   = 1'b0;
    data_addr_i = 32'h0;
    data_i      = 32'h0;
    #3;
    check("reset_count", 32'(sb_count_o), 32'd0);
    check("reset_empty", 32'(sb_empty_o), 32'd1);
    check("reset_data_o", data_o, 32'h0);
    #9 rst = 1'b1;
    step();

    // Preload index 4 through a store and a drain cycle.
    do_store(32'h10, 32'hDEAD_BEEF);
    check("preload_count", 32'(sb_count_o), 32'd1);
    step();
    check("preload_drained", 32'(sb_empty_o), 32'd1);
    data_ce_i   = 1'b1;
    data_addr_i = 32'h10;
    #2;
    check("load_array", data_o, 32'hDEAD_BEEF);
    check("load_array_empty", 32'(sb_empty_o), 32'd1);
    step();
    data_ce_i = 1'b0;

    // Store then load next cycle via bypass.
    do_store(32'h20, 32'h1234_5678);
    data_ce_i   = 1'b1;
    data_addr_i = 32'h20;
    #2;
    check("bypass_data", data_o, 32'h1234_5678);
    check("bypass_count", 32'(sb_count_o), 32'd1);
    step();
    data_ce_i = 1'b0;
    check("no_drain_on_load", 32'(sb_count_o), 32'd1);
    step();
    check("drained_after_idle", 32'(sb_count_o), 32'd0);
    do_load("alias_1020", 32'h1020, 32'h1234_5678);
    do_load("array_20", 32'h20, 32'h1234_5678);
    data_addr_i = 32'h20;
    #2;
    check("idle_data_zero", data_o, 32'h0);

    // Back-to-back stores: every store after the first drains the head.
    for (int i = 0; i < 4; i++) begin
      do_store(32'h40 + 32'(4 * i), 32'hA0 + 32'(i));
      check($sformatf("b2b_count_%0d", i), 32'(sb_count_o), 32'd1);
    end
    step();
    check("b2b_drained", 32'(sb_count_o), 32'd0);
    for (int i = 0; i < 4; i++)
      do_load($sformatf("b2b_read_%0d", i), 32'h40 + 32'(4 * i), 32'hA0 + 32'(i));

    // Stores interleaved with loads: count never exceeds one, data intact.
    do_store(32'h50, 32'hB0);
    do_load("il_bypass_50", 32'h50, 32'hB0);
    do_store(32'h54, 32'hB1);
    check("il_count", 32'(sb_count_o), 32'd1);
    do_load("il_array_50", 32'h50, 32'hB0);
    do_load("il_bypass_54", 32'h54, 32'hB1);
    check("il_count_hold", 32'(sb_count_o), 32'd1);

    // Two stores to one address under loads of other addresses.
    do_store(32'h80, 32'h1);
    do_load("same_ld_40", 32'h40, 32'hA0);
    do_store(32'h80, 32'h2);
    check("same_count", 32'(sb_count_o), 32'd1);
    do_load("same_ld_44", 32'h44, 32'hA1);
    do_load("same_ld_80", 32'h80, 32'h2);
    step();
    do_load("same_array_80", 32'h80, 32'h2);

    // Reset with a pending store: asynchronous clear, array keeps the old value.
    do_store(32'h60, 32'h1111_1111);
    step();
    do_store(32'h60, 32'h2222_2222);
    check("pre_rst_count", 32'(sb_count_o), 32'd1);
    #3 rst = 1'b0;
    #1;
    check("async_rst_count", 32'(sb_count_o), 32'd0);
    check("async_rst_empty", 32'(sb_empty_o), 32'd1);
    #2 rst = 1'b1;
    step();
    do_load("rst_keeps_array", 32'h60, 32'h1111_1111);
    do_load("rst_keeps_10", 32'h10, 32'hDEAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
